// File: rtl/cache_l2_assoc_if.sv
// Request, response and memory-side bus of the set-associative L2 core.
// slave: the cache side; master: the request queue plus memory side.
interface cache_l2_assoc_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ID_WIDTH-1:0]   req_id;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [ID_WIDTH-1:0]   rsp_id;
    logic [1:0]            rsp_op;
    logic [WORD_WIDTH-1:0] rsp_rdata;
    logic                  rsp_hit;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_wvalid;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  mem_rvalid;
    logic [WORD_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_id, req_op, req_addr, req_wdata,
        input  mem_req_ready, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_id, rsp_op, rsp_rdata,
        output rsp_hit, mem_req_valid, mem_req_write, mem_req_addr,
        output mem_wvalid, mem_wdata
    );

    modport master (
        output req_valid, req_id, req_op, req_addr, req_wdata,
        output mem_req_ready, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_id, rsp_op, rsp_rdata,
        input  rsp_hit, mem_req_valid, mem_req_write, mem_req_addr,
        input  mem_wvalid, mem_wdata
    );
endinterface

// File: rtl/cache_l2_assoc.sv
// N-way write-back, write-allocate L2 core, one request at a time.
// Ports: clk, rst (async high), bus = request/response/memory bus.
module cache_l2_assoc #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int INDEX_WIDTH    = 10,
    parameter int WAYS           = 2,
    parameter int ID_WIDTH       = 4
) (
    input logic             clk,
    input logic             rst,
    cache_l2_assoc_if.slave bus
);
    localparam int BYTE_BITS = $clog2(WORD_WIDTH / 8);
    localparam int OFF_BITS  = $clog2(WORDS_PER_LINE);
    localparam int LOW_BITS  = OFF_BITS + BYTE_BITS;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - LOW_BITS;
    localparam int WA        = ADDR_WIDTH - BYTE_BITS;
    localparam int SETS      = 1 << INDEX_WIDTH;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_PWB = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;
    localparam logic [OFF_BITS-1:0] LAST = OFF_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_DATA,
        S_FILL_REQ, S_FILL_DATA, S_REFILL, S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [ID_WIDTH-1:0]   id_q;
    logic [1:0]            op_q;
    logic [WA-1:0]         waddr_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic                  hit_q;
    logic [WAY_W-1:0]      way_q;
    logic [OFF_BITS-1:0]   cnt_q;

    logic [SETS-1:0]       valid_q [WAYS];
    logic [SETS-1:0]       dirty_q [WAYS];
    logic [WAY_W-1:0]      ptr_q [SETS];
    logic [TAG_WIDTH-1:0]  tag_q [WAYS][SETS];
    logic [WORD_WIDTH-1:0] data_q [WAYS][SETS][WORDS_PER_LINE];

    logic [TAG_WIDTH-1:0]   tag_a;
    logic [INDEX_WIDTH-1:0] idx_a;
    logic [OFF_BITS-1:0]    off_a;
    logic                   is_wr;

    assign tag_a = waddr_q[WA-1 -: TAG_WIDTH];
    assign idx_a = waddr_q[OFF_BITS +: INDEX_WIDTH];
    assign off_a = waddr_q[OFF_BITS-1:0];
    assign is_wr = (op_q == OP_WR) || (op_q == OP_PWB);

    logic             hit, inv_found, vict_dirty, hit_dirty;
    logic [WAY_W-1:0] hit_way, inv_way, vict_way;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx_a] && tag_q[w][idx_a] == tag_a) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[w][idx_a] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        vict_way   = inv_found ? inv_way : ptr_q[idx_a];
        vict_dirty = valid_q[vict_way][idx_a] && dirty_q[vict_way][idx_a];
        hit_dirty  = dirty_q[hit_way][idx_a];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (bus.req_valid) state_d = S_LOOKUP;
            S_LOOKUP:
                if (hit)
                    state_d = (op_q == OP_INV && hit_dirty)
                            ? S_WB_REQ : S_RESP;
                else if (op_q == OP_INV) state_d = S_RESP;
                else if (vict_dirty)     state_d = S_WB_REQ;
                else                     state_d = S_FILL_REQ;
            S_WB_REQ:
                if (bus.mem_req_ready) state_d = S_WB_DATA;
            S_WB_DATA:
                if (cnt_q == LAST)
                    state_d = (op_q == OP_INV) ? S_RESP : S_FILL_REQ;
            S_FILL_REQ:
                if (bus.mem_req_ready) state_d = S_FILL_DATA;
            S_FILL_DATA:
                if (bus.mem_rvalid && cnt_q == LAST) state_d = S_REFILL;
            S_REFILL: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control/metadata state; cleared by reset so an aborted miss
    // leaves no valid line behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q    <= '0;
            op_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            cnt_q   <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else begin
            unique case (state_q)
                S_IDLE:
                    if (bus.req_valid) begin
                        id_q    <= bus.req_id;
                        op_q    <= bus.req_op;
                        waddr_q <= bus.req_addr[ADDR_WIDTH-1:BYTE_BITS];
                        wdata_q <= bus.req_wdata;
                    end
                S_LOOKUP: begin
                    hit_q <= hit;
                    way_q <= hit ? hit_way : vict_way;
                    cnt_q <= '0;
                    if (hit && is_wr) dirty_q[hit_way][idx_a] <= 1'b1;
                    if (hit && op_q == OP_INV && !hit_dirty)
                        valid_q[hit_way][idx_a] <= 1'b0;
                end
                S_WB_DATA: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST && op_q == OP_INV) begin
                        valid_q[way_q][idx_a] <= 1'b0;
                        dirty_q[way_q][idx_a] <= 1'b0;
                    end
                end
                S_FILL_DATA:
                    if (bus.mem_rvalid) cnt_q <= cnt_q + 1'b1;
                S_REFILL: begin
                    valid_q[way_q][idx_a] <= 1'b1;
                    dirty_q[way_q][idx_a] <= is_wr;
                    ptr_q[idx_a] <= (ptr_q[idx_a] == WAY_W'(WAYS - 1))
                                  ? '0 : ptr_q[idx_a] + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays are not reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (state_q == S_LOOKUP && hit && is_wr)
            data_q[hit_way][idx_a][off_a] <= wdata_q;
        if (state_q == S_FILL_DATA && bus.mem_rvalid)
            data_q[way_q][idx_a][cnt_q] <= bus.mem_rdata;
        if (state_q == S_REFILL) begin
            tag_q[way_q][idx_a] <= tag_a;
            if (is_wr) data_q[way_q][idx_a][off_a] <= wdata_q;
        end
    end

    // All outputs decode from the state register, so reset clears
    // them without waiting for a clock edge.
    logic rsp_on;
    assign rsp_on = (state_q == S_RESP) && (op_q != OP_PWB);

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.mem_req_valid = (state_q == S_WB_REQ)
                            || (state_q == S_FILL_REQ);
    assign bus.mem_req_write = (state_q == S_WB_REQ);
    assign bus.mem_req_addr  =
        (state_q == S_WB_REQ)
            ? {tag_q[way_q][idx_a], idx_a, {LOW_BITS{1'b0}}}
        : (state_q == S_FILL_REQ)
            ? {tag_a, idx_a, {LOW_BITS{1'b0}}}
        : '0;
    assign bus.mem_wvalid = (state_q == S_WB_DATA);
    assign bus.mem_wdata  = (state_q == S_WB_DATA)
                          ? data_q[way_q][idx_a][cnt_q] : '0;
    assign bus.rsp_valid  = rsp_on;
    assign bus.rsp_id     = rsp_on ? id_q : '0;
    assign bus.rsp_op     = rsp_on ? op_q : '0;
    assign bus.rsp_hit    = rsp_on & hit_q;
    assign bus.rsp_rdata  = rsp_on ? data_q[way_q][idx_a][off_a] : '0;
endmodule

// File: tb/tb_cache_l2_assoc.sv
// Directed bench for cache_l2_assoc: hits, misses, eviction,
// posted writeback, invalidate, memory stall and mid-fill reset.
module tb_cache_l2_assoc;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01;
    localparam logic [1:0] PWB = 2'b10, INV = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_l2_assoc_if bus ();
    cache_l2_assoc dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] fill_line [4];
    int stall_cycles = 0;
    int abort_beats = -1;

    logic        got_rsp;
    logic [31:0] r_rdata;
    logic        r_hit;
    logic [3:0]  r_id;
    logic [1:0]  r_op;
    int rsp_cyc, ready_cyc, mreq_cyc, beats_sent;
    logic [31:0] cmd_addr [$];
    logic        cmd_write [$];
    logic [31:0] wb_beats [$];
    logic stall_bad, early_wv, timeout;

    // Drives one request and plays the memory side until the cache
    // is idle again; cycle 1 is the cycle after the accepting edge.
    task automatic run_req(input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] id);
        int stall_left;
        int budget;
        bit fill_go, wb_done, held;
        logic [31:0] held_addr;
        got_rsp = 0; rsp_cyc = -1; ready_cyc = -1; mreq_cyc = -1;
        beats_sent = 0; stall_bad = 0; early_wv = 0; timeout = 0;
        cmd_addr.delete(); cmd_write.delete(); wb_beats.delete();
        r_rdata = '0; r_hit = 0; r_id = '0; r_op = '0;
        stall_left = stall_cycles;
        fill_go = 0; wb_done = 0; held = 0; held_addr = '0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_id = id;
        budget = 0;
        while (!bus.req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (bus.rsp_valid) begin
                got_rsp = 1; rsp_cyc = cyc; r_rdata = bus.rsp_rdata;
                r_hit = bus.rsp_hit; r_id = bus.rsp_id; r_op = bus.rsp_op;
            end
            if (bus.mem_wvalid) begin
                wb_beats.push_back(bus.mem_wdata);
                if (!wb_done) early_wv = 1;
            end
            if (fill_go && beats_sent < 4) begin
                if (beats_sent == abort_beats) begin
                    bus.mem_rvalid = 1'b0;
                    return;
                end
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata = fill_line[beats_sent];
                beats_sent++;
            end else begin
                bus.mem_rvalid = 1'b0;
            end
            if (held && !bus.mem_req_valid) stall_bad = 1;
            bus.mem_req_ready = 1'b0;
            if (bus.mem_req_valid) begin
                if (mreq_cyc < 0) mreq_cyc = cyc;
                if (held && bus.mem_req_addr !== held_addr) stall_bad = 1;
                held = 1; held_addr = bus.mem_req_addr;
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    bus.mem_req_ready = 1'b1;
                    cmd_addr.push_back(bus.mem_req_addr);
                    cmd_write.push_back(bus.mem_req_write);
                    if (bus.mem_req_write) wb_done = 1;
                    else fill_go = 1;
                    held = 0;
                end
            end
            if (cyc >= 2 && bus.req_ready) begin
                ready_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        bus.mem_req_ready = 1'b0;
        bus.mem_rvalid = 1'b0;
        timeout = (ready_cyc < 0);
        vectors++;
        if (timeout) begin
            miscompares++;
            $display("FAIL req_done: op %0d addr %h never returned to idle",
                     op, addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.req_ready, bus.rsp_valid, bus.mem_req_valid,
             bus.mem_wvalid, bus.mem_req_addr, bus.rsp_rdata} !==
            {1'b1, 3'b000, 64'h0}) begin
            miscompares++;
            $display("FAIL reset_outputs: ready %b rsp %b mreq %b wv %b",
                     bus.req_ready, bus.rsp_valid, bus.mem_req_valid,
                     bus.mem_wvalid);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rd_miss();
        fill_line = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_req(RD, 32'h0000_1004, 32'h0, 4'h5);
        vectors++;
        if ({cmd_addr.size(), cmd_addr[0], cmd_write[0]} !==
            {32'd1, 32'h0000_1000, 1'b0}) begin
            miscompares++;
            $display("FAIL miss_cmd: n %0d addr %h wr %b want 1 00001000 0",
                     cmd_addr.size(), cmd_addr[0], cmd_write[0]);
        end
        vectors++;
        if (mreq_cyc !== 2) begin
            miscompares++;
            $display("FAIL miss_mreq_cycle: got %0d want 2", mreq_cyc);
        end
        vectors++;
        if ({got_rsp, r_rdata, r_hit, r_id} !== {1'b1, 32'h22, 1'b0, 4'h5})
        begin
            miscompares++;
            $display("FAIL miss_rsp: v %b data %h hit %b id %h want 1 22 0 5",
                     got_rsp, r_rdata, r_hit, r_id);
        end
        vectors++;
        if (rsp_cyc !== 8) begin
            miscompares++;
            $display("FAIL miss_rsp_cycle: got %0d want 8", rsp_cyc);
        end
        run_req(RD, 32'h0000_1004, 32'h0, 4'h6);
        vectors++;
        if ({got_rsp, r_rdata, r_hit} !== {1'b1, 32'h22, 1'b1}) begin
            miscompares++;
            $display("FAIL hit_rsp: v %b data %h hit %b want 1 22 1",
                     got_rsp, r_rdata, r_hit);
        end
        vectors++;
        if ({rsp_cyc, ready_cyc, cmd_addr.size()} !== {32'd2, 32'd3, 32'd0})
        begin
            miscompares++;
            $display("FAIL hit_timing: rsp %0d ready %0d cmds %0d want 2 3 0",
                     rsp_cyc, ready_cyc, cmd_addr.size());
        end
    endtask

    task automatic test_wr_hit();
        run_req(WR, 32'h0000_1008, 32'hDEAD_BEEF, 4'h3);
        vectors++;
        if ({got_rsp, r_hit, r_rdata, r_op} !==
            {1'b1, 1'b1, 32'hDEAD_BEEF, WR}) begin
            miscompares++;
            $display("FAIL wr_hit: v %b hit %b data %h op %0d",
                     got_rsp, r_hit, r_rdata, r_op);
        end
        run_req(RD, 32'h0000_1008, 32'h0, 4'h4);
        vectors++;
        if ({r_hit, r_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL wr_readback: hit %b data %h want 1 deadbeef",
                     r_hit, r_rdata);
        end
    endtask

    task automatic test_evict();
        fill_line = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        run_req(RD, 32'h0010_1000, 32'h0, 4'h1);
        vectors++;
        if ({cmd_addr.size(), cmd_addr[0], cmd_write[0], r_rdata, r_hit} !==
            {32'd1, 32'h0010_1000, 1'b0, 32'hA1, 1'b0}) begin
            miscompares++;
            $display("FAIL second_way_fill: n %0d addr %h data %h hit %b",
                     cmd_addr.size(), cmd_addr[0], r_rdata, r_hit);
        end
        fill_line = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
        run_req(RD, 32'h0020_1000, 32'h0, 4'h2);
        vectors++;
        if ({cmd_addr.size(), cmd_addr[0], cmd_write[0]} !==
            {32'd2, 32'h0000_1000, 1'b1}) begin
            miscompares++;
            $display("FAIL evict_wb_cmd: n %0d addr %h wr %b",
                     cmd_addr.size(), cmd_addr[0], cmd_write[0]);
        end
        vectors++;
        if ({cmd_addr[1], cmd_write[1]} !== {32'h0020_1000, 1'b0}) begin
            miscompares++;
            $display("FAIL evict_fill_cmd: addr %h wr %b want 00201000 0",
                     cmd_addr[1], cmd_write[1]);
        end
        vectors++;
        if ({wb_beats.size(), wb_beats[0], wb_beats[1], wb_beats[2],
             wb_beats[3]} !== {32'd4, 32'h11, 32'h22, 32'hDEAD_BEEF,
                               32'h44}) begin
            miscompares++;
            $display("FAIL evict_beats: n %0d b2 %h want 4 beats, deadbeef",
                     wb_beats.size(), wb_beats[2]);
        end
        vectors++;
        if ({r_rdata, r_hit} !== {32'hB1, 1'b0}) begin
            miscompares++;
            $display("FAIL evict_rsp: data %h hit %b want b1 0",
                     r_rdata, r_hit);
        end
        run_req(RD, 32'h0010_1004, 32'h0, 4'h2);
        vectors++;
        if ({r_hit, r_rdata, cmd_addr.size()} !== {1'b1, 32'hA2, 32'd0})
        begin
            miscompares++;
            $display("FAIL way1_kept: hit %b data %h cmds %0d want 1 a2 0",
                     r_hit, r_rdata, cmd_addr.size());
        end
    endtask

    task automatic test_pwb_inv();
        run_req(PWB, 32'h0010_1004, 32'hCAFE_F00D, 4'h7);
        vectors++;
        if ({got_rsp, ready_cyc, cmd_addr.size()} !==
            {1'b0, 32'd3, 32'd0}) begin
            miscompares++;
            $display("FAIL pwb_posted: rsp %b ready %0d cmds %0d want 0 3 0",
                     got_rsp, ready_cyc, cmd_addr.size());
        end
        stall_cycles = 5;
        run_req(INV, 32'h0010_1004, 32'h0, 4'h8);
        stall_cycles = 0;
        vectors++;
        if ({stall_bad, early_wv} !== 2'b00) begin
            miscompares++;
            $display("FAIL wb_stall: unstable %b early_wvalid %b want 0 0",
                     stall_bad, early_wv);
        end
        vectors++;
        if ({cmd_addr.size(), cmd_addr[0], cmd_write[0]} !==
            {32'd1, 32'h0010_1000, 1'b1}) begin
            miscompares++;
            $display("FAIL inv_wb_cmd: n %0d addr %h wr %b",
                     cmd_addr.size(), cmd_addr[0], cmd_write[0]);
        end
        vectors++;
        if ({wb_beats.size(), wb_beats[0], wb_beats[1], wb_beats[3]} !==
            {32'd4, 32'hA1, 32'hCAFE_F00D, 32'hA4}) begin
            miscompares++;
            $display("FAIL inv_beats: n %0d b1 %h want 4 cafef00d",
                     wb_beats.size(), wb_beats[1]);
        end
        vectors++;
        if ({got_rsp, r_hit, r_op, r_rdata} !==
            {1'b1, 1'b1, INV, 32'hCAFE_F00D}) begin
            miscompares++;
            $display("FAIL inv_rsp: v %b hit %b op %0d data %h",
                     got_rsp, r_hit, r_op, r_rdata);
        end
        fill_line = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
        run_req(RD, 32'h0010_1004, 32'h0, 4'h9);
        vectors++;
        if ({r_hit, r_rdata, cmd_addr.size(), cmd_addr[0]} !==
            {1'b0, 32'hC2, 32'd1, 32'h0010_1000}) begin
            miscompares++;
            $display("FAIL after_inv: hit %b data %h cmds %0d want 0 c2 1",
                     r_hit, r_rdata, cmd_addr.size());
        end
    endtask

    task automatic test_reset_mid_fill();
        fill_line = '{32'hD1, 32'hD2, 32'hD3, 32'hD4};
        abort_beats = 2;
        run_req(RD, 32'h0000_3004, 32'h0, 4'hA);
        abort_beats = -1;
        vectors++;
        if ({beats_sent, bus.req_ready} !== {32'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_fill_busy: beats %0d ready %b want 2 0",
                     beats_sent, bus.req_ready);
        end
        #1;
        rst = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        #1;
        vectors++;
        if ({bus.req_ready, bus.rsp_valid, bus.mem_req_valid,
             bus.mem_wvalid, bus.mem_req_addr, bus.mem_wdata} !==
            {1'b1, 3'b000, 64'h0}) begin
            miscompares++;
            $display("FAIL async_reset: ready %b rsp %b mreq %b wv %b",
                     bus.req_ready, bus.rsp_valid, bus.mem_req_valid,
                     bus.mem_wvalid);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        fill_line = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
        run_req(RD, 32'h0000_3004, 32'h0, 4'hB);
        vectors++;
        if ({r_hit, r_rdata, cmd_addr.size(), cmd_addr[0], cmd_write[0]} !==
            {1'b0, 32'hE2, 32'd1, 32'h0000_3000, 1'b0}) begin
            miscompares++;
            $display("FAIL refetch: hit %b data %h cmds %0d addr %h",
                     r_hit, r_rdata, cmd_addr.size(), cmd_addr[0]);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_id = '0; bus.req_op = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_rd_miss();
        test_wr_hit();
        test_evict();
        test_pwb_inv();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
